// File: rtl/aes_pkg.sv
// Shared AES constants and types for the serial round engines.
// Byte i of a block sits at bits [127-8i -: 8].
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

endpackage

// File: rtl/sbox.sv
// Forward AES S-box as a combinational ROM.
// Counterpart of the inverse S-box used on the decrypt side.
module sbox (
  input  logic [7:0] addr,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[addr];

endmodule

// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes: BYTES_PER_CYCLE S-box lanes sweep the
// 16-byte state in place, one chunk of bytes per cycle.
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] data_out
);

  localparam int NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int LANE_W    = BYTES_PER_CYCLE * AES_BYTE_W;
  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 ||
        BYTES_PER_CYCLE == 4 || BYTES_PER_CYCLE == 8 ||
        BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Chunk NUM_STEPS-1 holds bytes 0..BPC-1, so step s maps to LAST-s.
  typedef logic [NUM_STEPS-1:0][LANE_W-1:0] work_t;

  aes_state_e state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, chunk;
  work_t work_q, work_d;
  logic [AES_BLOCK_W-1:0] dout_q, dout_d;
  logic [BYTES_PER_CYCLE-1:0][AES_BYTE_W-1:0] lane_in;
  logic [BYTES_PER_CYCLE-1:0][AES_BYTE_W-1:0] lane_out;

  assign chunk   = LAST - step_q;
  assign lane_in = work_q[chunk];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    sbox u_sbox (
      .addr (lane_in[g]),
      .dout (lane_out[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    work_d   = work_q;
    dout_d   = dout_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = data_in;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d[chunk] = lane_out;
        if (step_q == LAST) begin
          dout_d  = work_d;
          state_d = DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            work_d  = data_in;
            step_d  = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      work_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial: reference S-box derived from
// GF(2^8) inversion plus the affine map, across five lane widths.
module tb_sub_bytes_serial;

  logic         clk;
  logic         rst_n;
  logic [4:0]   iv, ir, ov, ordy;
  logic [127:0] din  [5];
  logic [127:0] dout [5];

  int n_chk;
  int n_err;
  logic [7:0] sb_ref [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int B = (g == 0) ? 4 : (g == 1) ? 1 :
                       (g == 2) ? 2 : (g == 3) ? 8 : 16;
    sub_bytes_serial #(.BYTES_PER_CYCLE(B)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .data_in   (din[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .data_out  (dout[g])
    );
  end

  function automatic int bpc_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
               ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = sb_ref[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a block, wait for accept, then count edges to out_valid.
  task automatic send(input int k, input logic [127:0] d,
                      input bit noise, output int lat);
    int n;
    din[k] = d;
    iv[k]  = 1'b1;
    n = 0;
    while (!ir[k] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir[k]) chk("accept_timeout", 128'(ir[k]), 128'd1);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 64) begin
      if (noise) begin
        chk("busy_in_ready", 128'(ir[k]), 128'd0);
        din[k] = {$urandom, $urandom, $urandom, $urandom};
        iv[k]  = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    iv[k] = 1'b0;
  endtask

  task automatic take(input int k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk("out_valid_drop", 128'(ov[k]), 128'd0);
  endtask

  initial begin
    int lat;
    logic [127:0] v, a, b;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    for (int k = 0; k < 5; k++) din[k] = '0;
    for (int i = 0; i < 256; i++) sb_ref[i] = sbox_math(8'(i));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_data_out", dout[0], 128'h0);
    chk("rst_in_ready", 128'(ir[0]), 128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known bytes and the FIPS-197 round-1 state
    chk("ref_sbox", ref_sub({4{32'h0001_53ff}}), {4{32'h637c_ed16}});
    send(0, {4{32'h0001_53ff}}, 1'b0, lat);
    chk("byte_lat", 128'(lat), 128'd4);
    chk("byte_data", dout[0], {4{32'h637c_ed16}});
    take(0);
    send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, lat);
    chk("fips_data", dout[0], 128'hd42711aee0bf98f1b8b45de51e415230);
    take(0);

    for (int t = 0; t < 16; t++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      send(0, v, t[0], lat);
      chk("rand_lat", 128'(lat), 128'd4);
      chk("rand_data", dout[0], ref_sub(v));
      take(0);
    end

    // Hold off the consumer and confirm the result stays put
    v = {$urandom, $urandom, $urandom, $urandom};
    send(0, v, 1'b0, lat);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 128'(ov[0]), 128'd1);
      chk("bp_data", dout[0], ref_sub(v));
      chk("bp_in_ready", 128'(ir[0]), 128'd0);
      @(posedge clk); #1;
    end
    take(0);

    // Back-to-back: second block accepted on the handshake edge
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send(0, a, 1'b0, lat);
    chk("b2b_a_data", dout[0], ref_sub(a));
    din[0]  = b;
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk); #1;
    iv[0]   = 1'b0;
    ordy[0] = 1'b0;
    chk("b2b_busy", 128'(ov[0]), 128'd0);
    lat = 1;
    while (!ov[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_spacing", 128'(lat), 128'd5);
    chk("b2b_b_data", dout[0], ref_sub(b));
    take(0);

    // Reset part way through a block
    din[0] = {$urandom, $urandom, $urandom, $urandom};
    iv[0]  = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(ov[0]), 128'd0);
    chk("midrst_data", dout[0], 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_idle", 128'(ov[0]), 128'd0);
    v = {$urandom, $urandom, $urandom, $urandom};
    send(0, v, 1'b0, lat);
    chk("postrst_lat", 128'(lat), 128'd4);
    chk("postrst_data", dout[0], ref_sub(v));
    take(0);

    // Other lane widths on the FIPS state
    for (int k = 1; k < 5; k++) begin
      send(k, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, lat);
      chk("sweep_lat", 128'(lat), 128'(16 / bpc_of(k)));
      chk("sweep_data", dout[k], 128'hd42711aee0bf98f1b8b45de51e415230);
      v = {$urandom, $urandom, $urandom, $urandom};
      ordy[k] = 1'b1;
      din[k]  = v;
      iv[k]   = 1'b1;
      @(posedge clk); #1;
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      lat = 0;
      while (!ov[k] && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("sweep_rand", dout[k], ref_sub(v));
      take(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
